// File: rtl/narrow_9_4s_pkg.sv
// Shared datapath constants and buffer entry type for the 9-to-4 narrower.
package narrow_9_4s_pkg;

    localparam int IN_W  = 9;
    localparam int OUT_W = 4;

    localparam logic [OUT_W-1:0] SAT_POS  = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_NEG  = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] SAT_UMAX = {OUT_W{1'b1}};

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             ovf;
    } entry_t;

endpackage

// File: rtl/narrow_sat_core.sv
// Combinational saturate and overflow detect, signed or unsigned.
module narrow_sat_core
    import narrow_9_4s_pkg::*;
#(
    parameter int IN_W   = narrow_9_4s_pkg::IN_W,
    parameter int OUT_W  = narrow_9_4s_pkg::OUT_W,
    parameter int SIGNED = 1
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout,
    output logic             ovf
);

    localparam logic [OUT_W-1:0] POS  = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] NEG  = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] UMAX = {OUT_W{1'b1}};

    // Sign bit of the result plus every dropped bit must agree when signed.
    logic [IN_W-OUT_W:0] hi_s;
    logic [IN_W-OUT_W-1:0] hi_u;

    assign hi_s = din[IN_W-1:OUT_W-1];
    assign hi_u = din[IN_W-1:OUT_W];

    always_comb begin
        dout = din[OUT_W-1:0];
        ovf  = 1'b0;
        if (SIGNED != 0) begin
            ovf = !((&hi_s) || !(|hi_s));
            if (ovf) dout = din[IN_W-1] ? NEG : POS;
        end else begin
            ovf = |hi_u;
            if (ovf) dout = UMAX;
        end
    end

endmodule

// File: rtl/narrow_9_4s.sv
// 9-to-4 bit saturating narrower with 2-entry output buffer.
// Optional NARROW_OVF_CNT_EN adds an 8-bit saturating clip counter.
module narrow_9_4s
    import narrow_9_4s_pkg::*;
#(
    parameter int IN_W   = narrow_9_4s_pkg::IN_W,
    parameter int OUT_W  = narrow_9_4s_pkg::OUT_W,
    parameter int SIGNED = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             clr_ovf,
    output logic             ovf_sticky
`ifdef NARROW_OVF_CNT_EN
    ,
    output logic [7:0]       ovf_cnt
`endif
);

    entry_t     slot0;
    entry_t     slot1;
    entry_t     nw;
    logic [1:0] cnt;
    logic       push;
    logic       pop;

    narrow_sat_core #(
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .SIGNED (SIGNED)
    ) u_core (
        .din  (in_data),
        .dout (nw.data),
        .ovf  (nw.ovf)
    );

    assign in_ready  = (cnt < 2'd2);
    assign out_valid = (cnt != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = slot0.data;
    assign out_ovf   = slot0.ovf;

    // slot0 is always the head; push and pop together only happen at count 1.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt   <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            unique case (1'b1)
                (push && pop): begin
                    slot0 <= nw;
                end
                (push && !pop): begin
                    if (cnt == 2'd0) slot0 <= nw;
                    else             slot1 <= nw;
                    cnt <= cnt + 2'd1;
                end
                (pop && !push): begin
                    slot0 <= slot1;
                    cnt   <= cnt - 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)                ovf_sticky <= 1'b0;
        else if (push && nw.ovf) ovf_sticky <= 1'b1;
        else if (clr_ovf)        ovf_sticky <= 1'b0;
    end

`ifdef NARROW_OVF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_cnt <= 8'd0;
        end else if (push && nw.ovf) begin
            if (clr_ovf)               ovf_cnt <= 8'd1;
            else if (ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
        end else if (clr_ovf) begin
            ovf_cnt <= 8'd0;
        end
    end
`endif

endmodule

// File: tb/tb_narrow_9_4s.sv
// Directed self-checking bench for narrow_9_4s (signed and unsigned builds).
module tb_narrow_9_4s;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] out_data;
    logic       out_ovf;
    logic       out_valid;
    logic       out_ready;
    logic       clr_ovf;
    logic       ovf_sticky;

    logic [8:0] u_in_data;
    logic       u_in_valid;
    logic       u_in_ready;
    logic [3:0] u_out_data;
    logic       u_out_ovf;
    logic       u_out_valid;
    logic       u_out_ready;
    logic       u_clr_ovf;
    logic       u_ovf_sticky;

`ifdef NARROW_OVF_CNT_EN
    logic [7:0] ovf_cnt;
    logic [7:0] u_ovf_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    narrow_9_4s #(.SIGNED(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_ovf    (out_ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .clr_ovf    (clr_ovf),
        .ovf_sticky (ovf_sticky)
`ifdef NARROW_OVF_CNT_EN
        ,
        .ovf_cnt    (ovf_cnt)
`endif
    );

    narrow_9_4s #(.SIGNED(0)) dut_u (
        .clk        (clk),
        .rst        (rst),
        .in_data    (u_in_data),
        .in_valid   (u_in_valid),
        .in_ready   (u_in_ready),
        .out_data   (u_out_data),
        .out_ovf    (u_out_ovf),
        .out_valid  (u_out_valid),
        .out_ready  (u_out_ready),
        .clr_ovf    (u_clr_ovf),
        .ovf_sticky (u_ovf_sticky)
`ifdef NARROW_OVF_CNT_EN
        ,
        .ovf_cnt    (u_ovf_cnt)
`endif
    );

    typedef struct {
        logic [8:0] din;
        logic [3:0] exp_data;
        logic       exp_ovf;
    } vec_t;

    vec_t sv [6];
    vec_t uv [2];
    logic sticky_exp;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    initial begin
        sv[0] = '{9'h005, 4'h5, 1'b0};
        sv[1] = '{9'h007, 4'h7, 1'b0};
        sv[2] = '{9'h008, 4'h7, 1'b1};
        sv[3] = '{9'h1F8, 4'h8, 1'b0};
        sv[4] = '{9'h1F7, 4'h8, 1'b1};
        sv[5] = '{9'h1F0, 4'h8, 1'b1};
        uv[0] = '{9'h012, 4'hF, 1'b1};
        uv[1] = '{9'h00E, 4'hE, 1'b0};

        rst = 1'b0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
        u_in_data = '0; u_in_valid = 1'b0; u_out_ready = 1'b0;
        u_clr_ovf = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_sticky", ovf_sticky, 0);
        check("rst_in_ready", in_ready, 1);

        // First word with consumer stalled: one-cycle latency.
        in_data = 9'h005; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("first_valid", out_valid, 1);
        check("first_data", out_data, 4'h5);
        check("first_ovf", out_ovf, 0);
        check("first_sticky", ovf_sticky, 0);
        out_ready = 1'b1;
        tick();
        check("first_pop", out_valid, 0);

        sticky_exp = 1'b0;
        for (int i = 1; i < 6; i++) begin
            in_data = sv[i].din; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            sticky_exp = sticky_exp | sv[i].exp_ovf;
            check($sformatf("vec%0d_valid", i), out_valid, 1);
            check($sformatf("vec%0d_data", i), out_data, sv[i].exp_data);
            check($sformatf("vec%0d_ovf", i), out_ovf, sv[i].exp_ovf);
            check($sformatf("vec%0d_sticky", i), ovf_sticky, sticky_exp);
            tick();
            check($sformatf("vec%0d_drain", i), out_valid, 0);
        end

        // Backpressure: fill both entries, third word refused.
        out_ready = 1'b0;
        in_data = 9'h003; in_valid = 1'b1;
        tick();
        check("bp_ready1", in_ready, 1);
        in_data = 9'h1FC;
        tick();
        check("bp_full", in_ready, 0);
        in_data = 9'h006;
        tick();
        in_valid = 1'b0;
        check("bp_hold_data", out_data, 4'h3);
        check("bp_still_full", in_ready, 0);
        out_ready = 1'b1;
        tick();
        check("bp_pop1_data", out_data, 4'hC);
        check("bp_pop1_ovf", out_ovf, 0);
        check("bp_ready_back", in_ready, 1);
        tick();
        check("bp_drained", out_valid, 0);

        // Streaming push and pop together at count 1.
        for (int i = 1; i <= 3; i++) begin
            in_data = 9'(i); in_valid = 1'b1;
            tick();
            check($sformatf("strm%0d_data", i), out_data, 4'(i));
            check($sformatf("strm%0d_rdy", i), in_ready, 1);
            check($sformatf("strm%0d_vld", i), out_valid, 1);
        end
        in_valid = 1'b0;
        tick();
        check("strm_drain", out_valid, 0);

        // Sticky clear, then clear racing a clipped accept.
        clr_ovf = 1'b1;
        tick();
        check("clr_sticky", ovf_sticky, 0);
        in_data = 9'h100; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("clr_set_wins", ovf_sticky, 1);
        check("clr_100_data", out_data, 4'h8);
        check("clr_100_ovf", out_ovf, 1);
        tick();
        clr_ovf = 1'b0;
        check("clr_after", ovf_sticky, 0);

        // Unsigned instance.
        u_out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            u_in_data = uv[i].din; u_in_valid = 1'b1;
            tick();
            u_in_valid = 1'b0;
            check($sformatf("u%0d_data", i), u_out_data, uv[i].exp_data);
            check($sformatf("u%0d_ovf", i), u_out_ovf, uv[i].exp_ovf);
            tick();
        end
        check("u_sticky", u_ovf_sticky, 1);

        // Reset with two entries buffered.
        out_ready = 1'b0;
        in_data = 9'h0FF; in_valid = 1'b1;
        tick();
        in_data = 9'h002;
        tick();
        in_valid = 1'b0;
        check("pre_rst_full", in_ready, 0);
        check("pre_rst_sticky", ovf_sticky, 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_sticky", ovf_sticky, 0);
        check("mid_rst_data", out_data, 0);
        tick();
        check("mid_rst_empty", out_valid, 0);

`ifdef NARROW_OVF_CNT_EN
        check("cnt_rst", ovf_cnt, 0);
        out_ready = 1'b1;
        in_data = 9'h0F0; in_valid = 1'b1;
        for (int i = 0; i < 255; i++) tick();
        check("cnt_255", ovf_cnt, 8'hFF);
        for (int i = 0; i < 45; i++) tick();
        check("cnt_300", ovf_cnt, 8'hFF);
        clr_ovf = 1'b1;
        tick();
        check("cnt_clr_clip", ovf_cnt, 1);
        in_valid = 1'b0;
        tick();
        clr_ovf = 1'b0;
        check("cnt_clr", ovf_cnt, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
